spi_shift_engine: RTL

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

---
 rtl/spi_pkg.sv | 16 +
 rtl/edge_tick.sv | 37 +++
 rtl/spi_shift_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine and its helpers.
// Contents: the FSM state encoding (2 bits) and the default frame
// length / lead-time constants used as parameter defaults.
package spi_pkg;

  localparam int SPI_DEF_WIDTH      = 8;
  localparam int SPI_DEF_LEAD_TICKS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_t;

endpackage

// File: rtl/edge_tick.sv
// edge_tick: turns a slow square wave (same clock domain) into a
// one-cycle tick on each of its rising edges.
// Ports:
//   clkin - system clock, rising edge
//   rst   - asynchronous active-high reset
//   din   - square wave input (e.g. clockdiv output)
//   tick  - one-cycle pulse per rising edge of din
// After reset the first detected edge is swallowed so that a wave that
// was already high at release cannot produce a spurious tick.
module edge_tick (
  input  logic clkin,
  input  logic rst,
  input  logic din,
  output logic tick
);

  logic r_q1;
  logic r_q2;
  logic r_armed;
  logic w_edge;

  assign w_edge = r_q1 & ~r_q2;
  assign tick   = w_edge & r_armed;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_q1    <= 1'b0;
      r_q2    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_q1    <= din;
      r_q2    <= r_q1;
      r_armed <= r_armed | w_edge;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master shift engine paced by an external
// divider wave. Each rising edge of div_in is one tick (half SCK period).
// Frame: cs_n falls, LEAD_TICKS ticks of lead, 2*WIDTH SCK edges,
// one trail tick on which cs_n rises and done pulses.
// Optional build macro: SPI_LSB_FIRST_EN adds input lsb_first
// (latched at start) selecting LSB-first for both tx and rx.
// Ports:
//   clkin, rst        - clock (rising edge), async active-high reset
//   div_in            - divider square wave, one tick per rising edge
//   start, tx_data    - frame request and data to send
//   cpol, cpha, miso  - SPI mode bits (latched at start), serial input
//   sclk, mosi, cs_n  - SPI bus outputs
//   busy, done        - frame in progress, one-cycle completion pulse
//   rx_data           - received word, updated once per completed frame
//   dbg_state         - current FSM state for observation
// Handshake: start is taken only in IDLE and only when done is low; the
// accepting cycle raises busy on the next edge, and busy stays high
// until the cycle that pulses done. start at any other time is ignored.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int WIDTH      = SPI_DEF_WIDTH,       // 2..32
  parameter int LEAD_TICKS = SPI_DEF_LEAD_TICKS   // >= 1
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             div_in,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             miso,
`ifdef SPI_LSB_FIRST_EN
  input  logic             lsb_first,
`endif
  output logic             sclk,
  output logic             mosi,
  output logic             cs_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output spi_state_t       dbg_state
);

  localparam int CNT_MAX = (2 * WIDTH > LEAD_TICKS) ? 2 * WIDTH : LEAD_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(LEAD_TICKS - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * WIDTH - 1);

  spi_state_t       r_state;
  spi_state_t       w_state_next;
  logic             w_tick;
  logic             w_accept;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx_sh;
  logic [WIDTH-1:0] r_rx;
  logic             r_cpha;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs_n;
  logic             r_busy;
  logic             r_done;
  logic             w_lsb;
  logic             w_lsb_in;
  logic             w_lead_last;
  logic             w_shift_last;
  logic             w_odd;
  logic             w_sample;
  logic             w_advance;
  logic [CNT_W-1:0] w_ord;
  logic [WIDTH-1:0] w_tx_msb_sh;
  logic [WIDTH-1:0] w_tx_lsb_sh;
  logic             w_tx_bit;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_rx_shifted;
  logic [WIDTH-1:0] w_rx_upd;

  edge_tick u_edge_tick (
    .clkin (clkin),
    .rst   (rst),
    .din   (div_in),
    .tick  (w_tick)
  );

`ifdef SPI_LSB_FIRST_EN
  logic r_lsb;
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_lsb <= 1'b0;
    end else if (w_accept) begin
      r_lsb <= lsb_first;
    end
  end
  assign w_lsb    = r_lsb;
  assign w_lsb_in = lsb_first;
`else
  assign w_lsb    = 1'b0;
  assign w_lsb_in = 1'b0;
`endif

  assign w_lead_last  = (r_cnt == LEAD_LAST);
  assign w_shift_last = (r_cnt == SHIFT_LAST);
  // r_cnt counts SHIFT ticks already taken, so the tick being processed
  // is number r_cnt+1; it is odd (a leading edge) when r_cnt is even.
  assign w_odd        = ~r_cnt[0];
  assign w_sample     = r_cpha ? ~w_odd : w_odd;
  // cpha=0 already shows the first bit from LEAD entry, so it advances on
  // trailing edges and must not advance past the last bit.
  assign w_advance    = r_cpha ? w_odd : (~w_odd & ~w_shift_last);

  // Ordinal of the bit to present on this advance: cpha=1 presents bit 0
  // on tick 1; cpha=0 presents bit 1 on tick 2, bit 2 on tick 4, ...
  assign w_ord        = r_cpha ? (r_cnt >> 1) : ((r_cnt + CNT_W'(1)) >> 1);
  assign w_tx_msb_sh  = r_tx << w_ord;
  assign w_tx_lsb_sh  = r_tx >> w_ord;
  assign w_tx_bit     = w_lsb ? w_tx_lsb_sh[0] : w_tx_msb_sh[WIDTH-1];
  assign w_first_bit  = w_lsb_in ? tx_data[0] : tx_data[WIDTH-1];

  assign w_rx_shifted = w_lsb ? {miso, r_rx_sh[WIDTH-1:1]}
                              : {r_rx_sh[WIDTH-2:0], miso};
  // With cpha=1 the final sample lands on the final tick, so the word
  // published at the end must include this tick's sample.
  assign w_rx_upd     = w_sample ? w_rx_shifted : r_rx_sh;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_done) begin
          w_accept     = 1'b1;
          w_state_next = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (w_tick && w_lead_last) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_tick && w_shift_last) w_state_next = ST_TRAIL;
      end
      ST_TRAIL: begin
        if (w_tick) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_tx    <= '0;
      r_rx_sh <= '0;
      r_rx    <= '0;
      r_cpha  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_tx    <= tx_data;
        r_cpha  <= cpha;
        r_sclk  <= cpol;
        r_cs_n  <= 1'b0;
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_rx_sh <= '0;
        if (!cpha) r_mosi <= w_first_bit;
      end else if (w_tick) begin
        case (r_state)
          ST_LEAD: begin
            r_cnt <= w_lead_last ? '0 : r_cnt + CNT_W'(1);
          end
          ST_SHIFT: begin
            r_sclk <= ~r_sclk;
            r_cnt  <= w_shift_last ? '0 : r_cnt + CNT_W'(1);
            if (w_sample)     r_rx_sh <= w_rx_shifted;
            if (w_advance)    r_mosi  <= w_tx_bit;
            if (w_shift_last) r_rx    <= w_rx_upd;
          end
          ST_TRAIL: begin
            r_cs_n <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign cs_n      = r_cs_n;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rx_data   = r_rx;
  assign dbg_state = r_state;

endmodule
